// File: rtl/line_follow_pkg.sv
// Shared types and constants for the line-follow error path.
package line_follow_pkg;

   // Sequencer phases: idle, clear accumulator, walk the 8 terms, publish result
   typedef enum logic [1:0] {IDLE, CLR, ACCUM, DONE} err_seq_state_t;

   // Mux select codes; odd codes are left sensors, even codes right sensors
   localparam logic [2:0] SEL_R0 = 3'd0;
   localparam logic [2:0] SEL_L0 = 3'd1;
   localparam logic [2:0] SEL_R1 = 3'd2;
   localparam logic [2:0] SEL_L1 = 3'd3;
   localparam logic [2:0] SEL_R2 = 3'd4;
   localparam logic [2:0] SEL_L2 = 3'd5;
   localparam logic [2:0] SEL_R3 = 3'd6;
   localparam logic [2:0] SEL_L3 = 3'd7;

   // Left readings are subtracted; the LSB of the select marks a left term
   function automatic logic sel_is_left(input logic [2:0] s);
      return s[0];
   endfunction

endpackage

// File: rtl/err_compute_seq.sv
// Control sequencer for the line-follow error datapath.
// Each IR sample set: clear accumulator, accumulate 8 weighted terms, pulse err_vld.
// One extra sample set may be queued while busy; a further one is dropped and flagged.
module err_compute_seq #(
   parameter int unsigned NUM_TERMS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       IR_vld,
   output logic       clr_accum,
   output logic       en_accum,
   output logic       sub,
   output logic [2:0] sel,
   output logic       err_vld,
   output logic       busy,
   output logic       ovr
);
   import line_follow_pkg::*;

   // Counter value of the final term; the 3-bit counter wraps to 0 on the exit
   localparam logic [2:0] LAST_TERM = 3'(NUM_TERMS - 1);

   err_seq_state_t state_q, state_d;
   logic [2:0]     cnt_q, cnt_d;
   logic           pend_q, pend_d;
   logic           ovr_q, ovr_d;

   // State, term counter and pending/overrun flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
      end
   end

   // Next-state, counter and sample-set queueing
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      ovr_d   = ovr_q;

      // A pulse while busy is queued once; a second one is lost
      if (IR_vld && (state_q != IDLE)) begin
         if (pend_q) begin
            ovr_d = 1'b1;
         end else begin
            pend_d = 1'b1;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (IR_vld || pend_q) begin
               state_d = CLR;
               pend_d  = 1'b0;
            end
         end
         CLR: begin
            state_d = ACCUM;
            cnt_d   = '0;
         end
         ACCUM: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == LAST_TERM) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // A pulse in this cycle counts as queued, so go straight to CLR
            if (pend_q || IR_vld) begin
               state_d = CLR;
               pend_d  = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore output decode from registered state and counter only
   always_comb begin
      clr_accum = (state_q == CLR);
      en_accum  = (state_q == ACCUM);
      sel       = SEL_R0;
      sub       = 1'b0;
      if (state_q == ACCUM) begin
         sel = cnt_q;
         sub = sel_is_left(cnt_q);
      end
      err_vld = (state_q == DONE);
      busy    = (state_q != IDLE);
      ovr     = ovr_q;
   end

endmodule

// File: tb/tb_err_compute_seq.sv
// Self-checking bench for err_compute_seq with a behavioural error accumulator.
module tb_err_compute_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       IR_vld = 1'b0;
   logic       clr_accum, en_accum, sub, err_vld, busy, ovr;
   logic [2:0] sel;

   always #10 clk = ~clk;

   err_compute_seq #(.NUM_TERMS(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .IR_vld    (IR_vld),
      .clr_accum (clr_accum),
      .en_accum  (en_accum),
      .sub       (sub),
      .sel       (sel),
      .err_vld   (err_vld),
      .busy      (busy),
      .ovr       (ovr)
   );

   // Edge counter: after posedge n, cyc == n
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Datapath stand-in: weighted 8:1 mux feeding an add/sub accumulator
   logic [11:0] ir_r [4];
   logic [11:0] ir_l [4];
   logic [11:0] rd;
   logic [15:0] term;
   logic [15:0] acc;

   always_comb begin
      rd   = sel[0] ? ir_l[sel[2:1]] : ir_r[sel[2:1]];
      term = 16'(rd) << sel[2:1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         acc <= '0;
      else if (clr_accum) acc <= '0;
      else if (en_accum)  acc <= sub ? acc - term : acc + term;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Observation logs
   int done_t[$];
   int done_v[$];
   int sel_log[$];
   int sub_log[$];
   int busy_cyc = 0;
   int clr_cyc = 0;

   always @(negedge clk) begin
      if (err_vld) begin
         done_t.push_back(cyc + 1);
         done_v.push_back(int'(acc));
      end
      if (en_accum) begin
         sel_log.push_back(int'(sel));
         sub_log.push_back(int'(sub));
      end
      if (busy) busy_cyc++;
      if (clr_accum) clr_cyc++;
      check("clr_en_exclusive", int'(clr_accum && en_accum), 0);
      check("sel_sub_idle_zero", int'(!en_accum && (sel != 3'd0 || sub)), 0);
   end

   // Reference: each accepted set takes 10 cycles to err_vld; one set may wait
   int  pulses[$];
   int  exp_done[$];
   bit  exp_ovr;

   task automatic run_model();
      int cur;
      bit pend;
      exp_done.delete();
      exp_ovr = 1'b0;
      cur = -1000;
      pend = 1'b0;
      foreach (pulses[i]) begin
         int t;
         t = pulses[i];
         if (pend && cur < t) begin
            cur += 10;
            exp_done.push_back(cur);
            pend = 1'b0;
         end
         if (t > cur) begin
            cur = t + 10;
            exp_done.push_back(cur);
         end else if (pend) begin
            exp_ovr = 1'b1;
         end else begin
            pend = 1'b1;
         end
      end
      if (pend) begin
         cur += 10;
         exp_done.push_back(cur);
      end
   endtask

   function automatic int exp_err();
      int s = 0;
      for (int i = 0; i < 4; i++) s += (int'(ir_r[i]) - int'(ir_l[i])) * (1 << i);
      return s & 32'hFFFF;
   endfunction

   task automatic set_readings(input logic [11:0] r, input logic [11:0] l);
      for (int i = 0; i < 4; i++) begin
         ir_r[i] = r;
         ir_l[i] = l;
      end
   endtask

   task automatic set_random_readings();
      for (int i = 0; i < 4; i++) begin
         ir_r[i] = 12'($urandom_range(0, 4095));
         ir_l[i] = 12'($urandom_range(0, 4095));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #5;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive pulses at the given cycle offsets, let the DUT drain, compare to model
   task automatic run_scenario(input string name, input int offs[$]);
      int last;
      last = 0;
      foreach (offs[j]) if (offs[j] > last) last = offs[j];
      pulses.delete();
      done_t.delete();
      done_v.delete();
      sel_log.delete();
      sub_log.delete();
      busy_cyc = 0;
      clr_cyc = 0;
      for (int i = 0; i <= last; i++) begin
         @(negedge clk);
         IR_vld = 1'b0;
         foreach (offs[j]) if (offs[j] == i) IR_vld = 1'b1;
         if (IR_vld) pulses.push_back(cyc + 1);
      end
      @(negedge clk);
      IR_vld = 1'b0;
      repeat (40) @(negedge clk);
      run_model();
      check({name, " err_vld_count"}, done_t.size(), exp_done.size());
      foreach (exp_done[i]) begin
         if (i < done_t.size()) begin
            check({name, " err_vld_latency"}, done_t[i] - pulses[0], exp_done[i] - pulses[0]);
            check({name, " error_value"}, done_v[i], exp_err());
         end
      end
      check({name, " ovr"}, int'(ovr), int'(exp_ovr));
      check({name, " busy_cycles"}, busy_cyc, 10 * exp_done.size());
      check({name, " clr_cycles"}, clr_cyc, exp_done.size());
   endtask

   initial begin
      int offs[$];
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int offs[$];
      set_readings(12'h000, 12'h000);
      #3;
      check("reset_outputs", int'({clr_accum, en_accum, sub, sel, err_vld, busy, ovr}), 0);
      do_reset();

      // Reset asserted mid-accumulation abandons the set
      set_readings(12'h100, 12'h000);
      @(negedge clk);
      IR_vld = 1'b1;
      @(negedge clk);
      IR_vld = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_accum_en", int'(en_accum), 1);
      #3 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", int'({clr_accum, en_accum, sub, sel, err_vld, busy, ovr}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      done_t.delete();
      busy_cyc = 0;
      repeat (20) @(negedge clk);
      check("no_err_vld_after_reset", done_t.size(), 0);
      check("idle_after_reset", busy_cyc, 0);

      // Single set, right readings only; also check the term walk order
      do_reset();
      set_readings(12'h100, 12'h000);
      offs = '{0};
      run_scenario("single", offs);
      check("single sel_walk_len", sel_log.size(), 8);
      foreach (sel_log[i]) begin
         check("single sel_order", sel_log[i], i);
         check("single sub_order", sub_log[i], i % 2);
      end

      // Left readings only: negative error
      do_reset();
      set_readings(12'h000, 12'hFFF);
      offs = '{0};
      run_scenario("signed", offs);

      // Back-to-back via pend
      do_reset();
      set_random_readings();
      offs = '{0, 5};
      run_scenario("back_to_back", offs);

      // Overrun: third pulse dropped
      do_reset();
      set_random_readings();
      offs = '{0, 3, 6};
      run_scenario("overrun", offs);

      // Pulse in the DONE cycle
      do_reset();
      set_random_readings();
      offs = '{0, 10};
      run_scenario("coincident", offs);

      // Randomized pulse trains
      for (int n = 0; n < 6; n++) begin
         int t;
         do_reset();
         set_random_readings();
         offs.delete();
         t = 0;
         offs.push_back(t);
         for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
            t += int'($urandom_range(1, 14));
            offs.push_back(t);
         end
         run_scenario("random", offs);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
